// File: rtl/cv_mem_pkg.sv
// Shared types and helpers for the cartridge memory arbiter.
// Holds the arbiter state encoding, the default memory address width,
// the page-mask width and the page-mask fill helper.
package cv_mem_pkg;

  localparam int MEM_AW_DEF = 20;
  localparam int PAGE_W     = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DL_WR  = 2'd2
  } arb_state_e;

  // Set every bit below the highest set bit, e.g. 000101 -> 000111.
  function automatic logic [PAGE_W-1:0] fill_mask(input logic [PAGE_W-1:0] page);
    logic [PAGE_W-1:0] m;
    m = page;
    m = m | (m >> 3'd1);
    m = m | (m >> 3'd2);
    m = m | (m >> 3'd4);
    return m;
  endfunction

endpackage

// File: rtl/cv_dl_buf.sv
// One-entry loader write buffer with a sticky overflow flag.
// A write is accepted when the buffer is empty or is being drained in the
// same cycle; otherwise it is dropped and the overflow flag is set. The flag
// clears only on reset or at the start of a new download.
module cv_dl_buf
  import cv_mem_pkg::*;
#(
  parameter int AW = MEM_AW_DEF
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          dl_active_i,
  input  logic          dl_wr_i,
  input  logic [AW-1:0] dl_addr_i,
  input  logic [7:0]    dl_d_i,
  input  logic          drain_i,
  output logic          full_o,
  output logic          accept_o,
  output logic [AW-1:0] buf_addr_o,
  output logic [7:0]    buf_d_o,
  output logic          ovf_o
);

  logic          full_r;
  logic [AW-1:0] addr_r;
  logic [7:0]    d_r;
  logic          ovf_r;
  logic          act_q_r;
  logic          accept_s;
  logic          drop_s;
  logic          rise_s;

  assign accept_s = dl_wr_i & (~full_r | drain_i);
  assign drop_s   = dl_wr_i & full_r & ~drain_i;
  assign rise_s   = dl_active_i & ~act_q_r;

  assign full_o     = full_r;
  assign accept_o   = accept_s;
  assign buf_addr_o = addr_r;
  assign buf_d_o    = d_r;
  assign ovf_o      = ovf_r;

  // Buffer entry: load on accepted write, free when the memory write completes.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_r <= 1'b0;
      addr_r <= {AW{1'b0}};
      d_r    <= 8'h00;
    end else if (accept_s) begin
      full_r <= 1'b1;
      addr_r <= dl_addr_i;
      d_r    <= dl_d_i;
    end else if (drain_i) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  // Sticky overflow: cleared at download start, set by any dropped write.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      act_q_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      act_q_r <= dl_active_i;
      if (rise_s) begin
        ovf_r <= drop_s;
      end else if (drop_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

endmodule

// File: rtl/cv_cart_mem_arb.sv
// Cartridge memory arbiter: shares one memory port between Z80 cartridge
// reads and the ROM download loader, stretches Z80 reads with WAIT_n and
// derives the cartridge page mask from the downloaded image size.
// Optional build macro CV_CART_MEM_ARB_CACHE_EN adds a single-entry read tag
// so a repeated read of the same address is answered without memory traffic.
module cv_cart_mem_arb
  import cv_mem_pkg::*;
#(
  parameter int MEM_AW  = MEM_AW_DEF,
  parameter int DL_PRIO = 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              cart_ce_n_i,
  input  logic [5:0]        cart_page_i,
  input  logic [13:0]       cpu_a_i,
  input  logic              cpu_rd_n_i,
  output logic [7:0]        cpu_d_o,
  output logic              cpu_wait_n_o,
  input  logic              dl_active_i,
  input  logic              dl_wr_i,
  input  logic [MEM_AW-1:0] dl_addr_i,
  input  logic [7:0]        dl_d_i,
  output logic              dl_ovf_o,
  output logic [5:0]        cart_pages_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [7:0]        mem_d_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_q_i
);

  localparam logic DL_FIRST = (DL_PRIO != 32'sd0);

  arb_state_e        state_r;
  logic              sel_n_q_r;
  logic              det_r;
  logic              cpu_pend_r;
  logic [MEM_AW-1:0] cpu_addr_r;
  logic              wait_n_r;
  logic [7:0]        cpu_d_r;
  logic              req_r;
  logic              we_r;
  logic [MEM_AW-1:0] addr_r;
  logic [7:0]        d_r;
  logic              dl_act_q_r;
  logic [PAGE_W-1:0] max_page_r;
  logic [PAGE_W-1:0] pages_r;

  logic              sel_n_s;
  logic              fall_s;
  logic [MEM_AW-1:0] req_addr_s;
  logic              hit_s;
  logic              cap_s;
  logic              cpu_done_s;
  logic              dl_done_s;
  logic              cpu_go_s;
  logic              dl_rise_s;
  logic              dl_fall_s;
  logic              buf_full_s;
  logic              buf_accept_s;
  logic [MEM_AW-1:0] buf_addr_s;
  logic [7:0]        buf_d_s;
  logic              buf_ovf_s;
  logic [PAGE_W-1:0] wr_page_s;
  logic [PAGE_W-1:0] max_base_s;
  logic [PAGE_W-1:0] max_next_s;

  assign sel_n_s    = cart_ce_n_i | cpu_rd_n_i;
  assign fall_s     = sel_n_q_r & ~sel_n_s;
  assign req_addr_s = MEM_AW'({cart_page_i, cpu_a_i});
  assign cpu_done_s = (state_r == CPU_RD) & mem_ack_i;
  assign dl_done_s  = (state_r == DL_WR) & mem_ack_i;
  assign cap_s      = det_r & ~hit_s & (~cpu_pend_r | cpu_done_s);
  assign cpu_go_s   = cpu_pend_r & ~dl_active_i;
  assign dl_rise_s  = dl_active_i & ~dl_act_q_r;
  assign dl_fall_s  = ~dl_active_i & dl_act_q_r;
  assign wr_page_s  = dl_addr_i[MEM_AW-1 -: PAGE_W];

  assign cpu_d_o      = cpu_d_r;
  assign cpu_wait_n_o = wait_n_r;
  assign dl_ovf_o     = buf_ovf_s;
  assign cart_pages_o = pages_r;
  assign mem_req_o    = req_r;
  assign mem_we_o     = we_r;
  assign mem_addr_o   = addr_r;
  assign mem_d_o      = d_r;

  cv_dl_buf #(
    .AW (MEM_AW)
  ) u_dl_buf (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .dl_active_i (dl_active_i),
    .dl_wr_i     (dl_wr_i),
    .dl_addr_i   (dl_addr_i),
    .dl_d_i      (dl_d_i),
    .drain_i     (dl_done_s),
    .full_o      (buf_full_s),
    .accept_o    (buf_accept_s),
    .buf_addr_o  (buf_addr_s),
    .buf_d_o     (buf_d_s),
    .ovf_o       (buf_ovf_s)
  );

`ifdef CV_CART_MEM_ARB_CACHE_EN
  logic              tag_valid_r;
  logic [MEM_AW-1:0] tag_addr_r;

  assign hit_s = tag_valid_r & (tag_addr_r == req_addr_s);

  // Read tag: remember the last completed CPU read, drop it when stale.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tag_valid_r <= 1'b0;
      tag_addr_r  <= {MEM_AW{1'b0}};
    end else if (dl_rise_s) begin
      tag_valid_r <= 1'b0;
    end else if (cpu_done_s) begin
      tag_valid_r <= ~(buf_accept_s & (dl_addr_i == cpu_addr_r));
      tag_addr_r  <= cpu_addr_r;
    end else if (buf_accept_s & (dl_addr_i == tag_addr_r)) begin
      tag_valid_r <= 1'b0;
    end else begin
      tag_valid_r <= tag_valid_r;
    end
  end
`else
  assign hit_s = 1'b0;
`endif

  // CPU side: read-strobe edge detect, pending slot capture and WAIT_n.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sel_n_q_r  <= 1'b1;
      det_r      <= 1'b0;
      cpu_pend_r <= 1'b0;
      cpu_addr_r <= {MEM_AW{1'b0}};
      wait_n_r   <= 1'b1;
    end else begin
      sel_n_q_r <= sel_n_s;
      det_r     <= fall_s;
      if (cap_s) begin
        cpu_pend_r <= 1'b1;
        cpu_addr_r <= req_addr_s;
        wait_n_r   <= 1'b0;
      end else if (cpu_done_s) begin
        cpu_pend_r <= 1'b0;
        wait_n_r   <= 1'b1;
      end else begin
        cpu_pend_r <= cpu_pend_r;
        wait_n_r   <= wait_n_r;
      end
    end
  end

  // Arbiter FSM: issue one memory access at a time and hold it until ack.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      cpu_d_r <= 8'hFF;
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {MEM_AW{1'b0}};
      d_r     <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (buf_full_s && (DL_FIRST || !cpu_go_s)) begin
            state_r <= DL_WR;
            req_r   <= 1'b1;
            we_r    <= 1'b1;
            addr_r  <= buf_addr_s;
            d_r     <= buf_d_s;
          end else if (cpu_go_s) begin
            state_r <= CPU_RD;
            req_r   <= 1'b1;
            we_r    <= 1'b0;
            addr_r  <= cpu_addr_r;
          end else begin
            state_r <= IDLE;
          end
        end
        CPU_RD: begin
          if (mem_ack_i) begin
            cpu_d_r <= mem_q_i;
            req_r   <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= CPU_RD;
          end
        end
        DL_WR: begin
          if (mem_ack_i) begin
            req_r   <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DL_WR;
          end
        end
        default: begin
          req_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Running maximum page of the current download, including this cycle's write.
  always_comb begin
    max_base_s = max_page_r;
    max_next_s = max_page_r;
    if (dl_rise_s) begin
      max_base_s = {PAGE_W{1'b0}};
    end else begin
      max_base_s = max_page_r;
    end
    if (buf_accept_s && (wr_page_s > max_base_s)) begin
      max_next_s = wr_page_s;
    end else begin
      max_next_s = max_base_s;
    end
  end

  // Page tracking: publish the filled mask when the download ends.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dl_act_q_r <= 1'b0;
      max_page_r <= {PAGE_W{1'b0}};
      pages_r    <= {PAGE_W{1'b0}};
    end else begin
      dl_act_q_r <= dl_active_i;
      max_page_r <= max_next_s;
      if (dl_fall_s) begin
        pages_r <= fill_mask(max_next_s);
      end else begin
        pages_r <= pages_r;
      end
    end
  end

endmodule

// File: tb/tb_cv_cart_mem_arb.sv
// Directed bench for cv_cart_mem_arb with a small memory bridge model.
module tb_cv_cart_mem_arb;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        cart_ce_n_i = 1'b1;
  logic [5:0]  cart_page_i = 6'd0;
  logic [13:0] cpu_a_i = 14'd0;
  logic        cpu_rd_n_i = 1'b1;
  logic [7:0]  cpu_d_o;
  logic        cpu_wait_n_o;
  logic        dl_active_i = 1'b0;
  logic        dl_wr_i = 1'b0;
  logic [19:0] dl_addr_i = 20'd0;
  logic [7:0]  dl_d_i = 8'd0;
  logic        dl_ovf_o;
  logic [5:0]  cart_pages_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [19:0] mem_addr_o;
  logic [7:0]  mem_d_o;
  logic        mem_ack_i;
  logic [7:0]  mem_q_i;

  // bridge model state
  logic [7:0]  mem [logic [19:0]];
  logic        model_ack = 1'b0;
  logic        force_ack = 1'b0;
  logic [7:0]  mem_q_v = 8'h00;
  int          ack_dly = 0;
  int          cnt = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [19:0] last_addr = 20'd0;
  bit          op_we [$];

  int n_chk = 0;
  int n_bad = 0;

  assign mem_ack_i = model_ack | force_ack;
  assign mem_q_i   = mem_q_v;

  cv_cart_mem_arb dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .cart_ce_n_i  (cart_ce_n_i),
    .cart_page_i  (cart_page_i),
    .cpu_a_i      (cpu_a_i),
    .cpu_rd_n_i   (cpu_rd_n_i),
    .cpu_d_o      (cpu_d_o),
    .cpu_wait_n_o (cpu_wait_n_o),
    .dl_active_i  (dl_active_i),
    .dl_wr_i      (dl_wr_i),
    .dl_addr_i    (dl_addr_i),
    .dl_d_i       (dl_d_i),
    .dl_ovf_o     (dl_ovf_o),
    .cart_pages_o (cart_pages_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_d_o      (mem_d_o),
    .mem_ack_i    (mem_ack_i),
    .mem_q_i      (mem_q_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory bridge model: ack after ack_dly cycles of held request.
  always @(negedge clk_i) begin
    if (!mem_req_o) begin
      model_ack = 1'b0;
      cnt = 0;
    end else if (model_ack) begin
      model_ack = 1'b0;
    end else if (cnt >= ack_dly) begin
      model_ack = 1'b1;
      cnt = 0;
      last_addr = mem_addr_o;
      op_we.push_back(mem_we_o);
      if (mem_we_o) begin
        mem[mem_addr_o] = mem_d_o;
        n_wr++;
      end else begin
        n_rd++;
        mem_q_v = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 8'hEE;
      end
    end else begin
      cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cpu_read(input logic [5:0] pg, input logic [13:0] a,
                          input int max_cyc, output int low);
    low = 0;
    cart_page_i = pg;
    cpu_a_i     = a;
    cart_ce_n_i = 1'b0;
    cpu_rd_n_i  = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (!cpu_wait_n_o) low++;
      else if (low > 0) break;
    end
    cart_ce_n_i = 1'b1;
    cpu_rd_n_i  = 1'b1;
    tick();
    tick();
  endtask

  task automatic dl_write(input logic [19:0] a, input logic [7:0] d);
    dl_addr_i = a;
    dl_d_i    = d;
    dl_wr_i   = 1'b1;
    tick();
    dl_wr_i   = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_cpu_d"}, {24'd0, cpu_d_o}, 32'h0000_00FF);
    chk({pfx, "_wait_n"}, {31'd0, cpu_wait_n_o}, 32'd1);
    chk({pfx, "_ovf"}, {31'd0, dl_ovf_o}, 32'd0);
    chk({pfx, "_pages"}, {26'd0, cart_pages_o}, 32'd0);
    chk({pfx, "_req"}, {31'd0, mem_req_o}, 32'd0);
    chk({pfx, "_we"}, {31'd0, mem_we_o}, 32'd0);
    chk({pfx, "_addr"}, {12'd0, mem_addr_o}, 32'd0);
    chk({pfx, "_d"}, {24'd0, mem_d_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int base;
    int nrd0;
    mem[20'h00123] = 8'h5A;
    mem[20'h00010] = 8'h3C;

    // reset values
    tick(); tick();
    chk_reset_vals("rst");
    reset_n_i = 1'b1;
    tick();
    chk_reset_vals("rst_rel");

    // zero-wait CPU read of 0x8123 on page 0
    ack_dly = 0;
    cpu_read(6'd0, 14'h0123, 20, low);
    chk("rd_wait_clks", low, 32'd2);
    chk("rd_data", {24'd0, cpu_d_o}, 32'h5A);
    chk("rd_addr", {12'd0, last_addr}, 32'h00123);
    chk("rd_count", n_rd, 32'd1);
    chk("rd_release", {31'd0, cpu_wait_n_o}, 32'd1);

    // download ending at 0x1FFFF -> mask 000111
    dl_active_i = 1'b1;
    tick();
    dl_write(20'h00000, 8'h11);
    dl_write(20'h0C000, 8'h22);
    dl_write(20'h1FFFF, 8'h33);
    chk("dl_pages_before_fall", {26'd0, cart_pages_o}, 32'd0);
    dl_active_i = 1'b0;
    tick(); tick();
    chk("dl_pages", {26'd0, cart_pages_o}, 32'h07);
    chk("dl_ovf", {31'd0, dl_ovf_o}, 32'd0);
    chk("dl_wr_count", n_wr, 32'd3);
    chk("dl_last_byte", {24'd0, mem[20'h1FFFF]}, 32'h33);

    // simultaneous pending write and read: write first, wait held throughout
    base = op_we.size();
    cart_page_i = 6'd1;
    cpu_a_i     = 14'h0005;
    cart_ce_n_i = 1'b0;
    cpu_rd_n_i  = 1'b0;
    tick();
    dl_addr_i = 20'h04005;
    dl_d_i    = 8'h77;
    dl_wr_i   = 1'b1;
    tick();
    dl_wr_i = 1'b0;
    low = cpu_wait_n_o ? 0 : 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!cpu_wait_n_o) low++;
      else break;
    end
    cart_ce_n_i = 1'b1;
    cpu_rd_n_i  = 1'b1;
    tick(); tick();
    chk("prio_wait_clks", low, 32'd4);
    chk("prio_ops", op_we.size(), base + 2);
    if (op_we.size() >= base + 2) begin
      chk("prio_first_is_wr", {31'd0, op_we[base]}, 32'd1);
      chk("prio_second_is_rd", {31'd0, op_we[base+1]}, 32'd0);
    end
    chk("prio_data", {24'd0, cpu_d_o}, 32'h77);

    // download with no writes -> mask 000000
    dl_active_i = 1'b1;
    tick();
    dl_active_i = 1'b0;
    tick(); tick();
    chk("empty_dl_pages", {26'd0, cart_pages_o}, 32'd0);

    // back-to-back loader writes with slow ack -> second dropped
    ack_dly = 4;
    dl_active_i = 1'b1;
    tick();
    dl_addr_i = 20'h0C000; dl_d_i = 8'hA1; dl_wr_i = 1'b1;
    tick();
    dl_addr_i = 20'h0C001; dl_d_i = 8'hA2;
    tick();
    dl_wr_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("ovf_set", {31'd0, dl_ovf_o}, 32'd1);
    chk("ovf_first_written", {24'd0, mem[20'h0C000]}, 32'hA1);
    chk("ovf_second_dropped", {31'd0, mem.exists(20'h0C001)}, 32'd0);
    dl_active_i = 1'b0;
    tick(); tick();
    chk("ovf_pages", {26'd0, cart_pages_o}, 32'h03);
    chk("ovf_sticky", {31'd0, dl_ovf_o}, 32'd1);

    // reset while a CPU read is outstanding
    ack_dly = 10;
    cart_page_i = 6'd0;
    cpu_a_i     = 14'h0123;
    cart_ce_n_i = 1'b0;
    cpu_rd_n_i  = 1'b0;
    tick(); tick(); tick();
    chk("mid_req", {31'd0, mem_req_o}, 32'd1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    tick();
    reset_n_i   = 1'b1;
    cart_ce_n_i = 1'b1;
    cpu_rd_n_i  = 1'b1;
    tick();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    chk("stray_ack_d", {24'd0, cpu_d_o}, 32'hFF);
    chk("stray_ack_req", {31'd0, mem_req_o}, 32'd0);
    chk("stray_ack_wait", {31'd0, cpu_wait_n_o}, 32'd1);

    // repeated read of 0xC010, then loader write to it, then read again
    ack_dly = 0;
    nrd0 = n_rd;
    cpu_read(6'd0, 14'h0010, 20, low);
    chk("c1_wait_clks", low, 32'd2);
    chk("c1_data", {24'd0, cpu_d_o}, 32'h3C);
    cpu_read(6'd0, 14'h0010, 8, low);
`ifdef CV_CART_MEM_ARB_CACHE_EN
    chk("c2_wait_clks", low, 32'd0);
    chk("c2_mem_reads", n_rd - nrd0, 32'd1);
`else
    chk("c2_wait_clks", low, 32'd2);
    chk("c2_mem_reads", n_rd - nrd0, 32'd2);
`endif
    chk("c2_data", {24'd0, cpu_d_o}, 32'h3C);
    dl_write(20'h00010, 8'h4D);
    cpu_read(6'd0, 14'h0010, 20, low);
    chk("c3_wait_clks", low, 32'd2);
    chk("c3_data", {24'd0, cpu_d_o}, 32'h4D);
`ifdef CV_CART_MEM_ARB_CACHE_EN
    chk("c3_mem_reads", n_rd - nrd0, 32'd2);
`else
    chk("c3_mem_reads", n_rd - nrd0, 32'd3);
`endif

    // overflow cleared by the next download start
    ack_dly = 4;
    dl_active_i = 1'b1;
    tick();
    dl_addr_i = 20'h00200; dl_d_i = 8'h01; dl_wr_i = 1'b1;
    tick();
    dl_addr_i = 20'h00201; dl_d_i = 8'h02;
    tick();
    dl_wr_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("ovf2_set", {31'd0, dl_ovf_o}, 32'd1);
    dl_active_i = 1'b0;
    tick();
    dl_active_i = 1'b1;
    tick();
    chk("ovf2_clear_on_rise", {31'd0, dl_ovf_o}, 32'd0);
    dl_active_i = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
